// File: rtl/shim_trigger_pkg.sv
// ---------------------------------------------------------------------------
// shim_trigger_pkg
// Shared definitions for the trigger shim: command opcodes, the CANCEL word
// and the sequence player state encoding.
// ---------------------------------------------------------------------------
package shim_trigger_pkg;

    // Command opcodes, carried in cmd_word[31:29]
    localparam logic [2:0] SYNC_CH         = 3'd1;
    localparam logic [2:0] SET_LOCKOUT     = 3'd2;
    localparam logic [2:0] EXPECT_EXT_TRIG = 3'd3;
    localparam logic [2:0] DELAY           = 3'd4;
    localparam logic [2:0] FORCE_TRIG      = 3'd5;
    localparam logic [2:0] CANCEL          = 3'd7;

    localparam logic [31:0] CANCEL_WORD = {CANCEL, 29'd0};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_PUSH   = 3'd3,
        S_DONE   = 3'd4,
        S_CANCEL = 3'd5
    } seq_state_t;

    function automatic logic opcode_is_valid(input logic [2:0] op);
        return (op == SYNC_CH) || (op == SET_LOCKOUT) || (op == EXPECT_EXT_TRIG) ||
               (op == DELAY) || (op == FORCE_TRIG) || (op == CANCEL);
    endfunction

endpackage

// File: rtl/shim_trigger_seq_player.sv
// ---------------------------------------------------------------------------
// shim_trigger_seq_player
// Plays a preloaded list of trigger command words from the sequence RAM into
// the trigger command FIFO, optionally looping the list. A stop drops the
// rest of the list and pushes a CANCEL word so the trigger core aborts.
//
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   start, stop             one-cycle control pulses
//   seq_len, loop_count     list length / pass count (0 = forever), sampled on start
//   ram_rd_en, ram_addr     sequence RAM read port
//   ram_rd_data             RAM data, RAM_LATENCY cycles after ram_rd_en
//   cmd_fifo_wr_en/_data    command FIFO write port
//   cmd_fifo_full           command FIFO full
//   busy, done              status; done pulses on completion or after cancel
//   loops_remaining         passes left including the current one
//   bad_config              sticky error, cleared by the next accepted start
//
// Build option: SHIM_SEQ_OPCODE_CHECK_EN -- when defined, words with an
// unknown opcode are not forwarded; the player flags bad_config and cancels.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a valid start
// S_READ   | RAM read strobe for the current address
// S_WAIT   | waiting RAM_LATENCY cycles for read data
// S_PUSH   | writing the held word once the FIFO has room
// S_DONE   | one-cycle done pulse, then idle
// S_CANCEL | writing the CANCEL word once the FIFO has room
// ---------------------------------------------------------------------------
module shim_trigger_seq_player
    import shim_trigger_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W:0]   seq_len,
    input  logic [15:0]       loop_count,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rd_data,
    output logic              cmd_fifo_wr_en,
    output logic [31:0]       cmd_fifo_wr_data,
    input  logic              cmd_fifo_full,
    output logic              busy,
    output logic              done,
    output logic [15:0]       loops_remaining,
    output logic              bad_config
);

    localparam logic [ADDR_W:0] LP_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_len;
    logic [15:0]       r_loops;
    logic              r_inf;
    logic [31:0]       r_hold;
    logic              r_wait_cnt;
    logic              r_bad;

    logic w_cfg_ok;
    logic w_start_ok;
    logic w_last_word;
    logic w_last_pass;
    logic w_stop_hit;
    logic w_op_bad;

    assign w_cfg_ok    = (seq_len != '0) && (seq_len <= LP_MAX_LEN);
    assign w_start_ok  = start && w_cfg_ok;
    assign w_last_word = ({1'b0, r_addr} == (r_len - (ADDR_W+1)'(1)));
    assign w_last_pass = !r_inf && (r_loops == 16'd1);
    // S_DONE is already the terminal step of a run, so a stop there is moot.
    assign w_stop_hit  = stop && ((r_state == S_READ) || (r_state == S_WAIT) ||
                                  (r_state == S_PUSH));

`ifdef SHIM_SEQ_OPCODE_CHECK_EN
    assign w_op_bad = !opcode_is_valid(r_hold[31:29]);
`else
    assign w_op_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_READ;
            S_READ:   w_next = S_WAIT;
            S_WAIT:   if (r_wait_cnt == 1'b0) w_next = S_PUSH;
            S_PUSH: begin
                if (w_op_bad) begin
                    w_next = S_CANCEL;
                end else if (!cmd_fifo_full) begin
                    if (w_last_word && w_last_pass) w_next = S_DONE;
                    else                            w_next = S_READ;
                end
            end
            S_DONE:   w_next = S_IDLE;
            S_CANCEL: if (!cmd_fifo_full) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
        // Stop outranks everything, including a same-cycle push.
        if (w_stop_hit) w_next = S_CANCEL;
    end

    // Outputs
    always_comb begin
        ram_rd_en        = (r_state == S_READ);
        cmd_fifo_wr_en   = ((r_state == S_PUSH) && !cmd_fifo_full && !stop && !w_op_bad) ||
                           ((r_state == S_CANCEL) && !cmd_fifo_full);
        cmd_fifo_wr_data = (r_state == S_CANCEL) ? CANCEL_WORD : r_hold;
        done             = (r_state == S_DONE);
        busy             = (r_state != S_IDLE);
    end

    assign ram_addr        = r_addr;
    assign loops_remaining = r_loops;
    assign bad_config      = r_bad;

    // Datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_loops    <= '0;
            r_inf      <= 1'b0;
            r_hold     <= '0;
            r_wait_cnt <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_len   <= seq_len;
                            r_inf   <= (loop_count == 16'd0);
                            r_loops <= loop_count;
                            r_addr  <= '0;
                            r_bad   <= 1'b0;
                        end else begin
                            r_bad   <= 1'b1;
                        end
                    end
                end
                S_READ: r_wait_cnt <= 1'(RAM_LATENCY - 1);
                S_WAIT: begin
                    if (r_wait_cnt == 1'b0) r_hold <= ram_rd_data;
                    else                    r_wait_cnt <= r_wait_cnt - 1'b1;
                end
                S_PUSH: begin
                    if (!stop) begin
                        if (w_op_bad) begin
                            r_bad <= 1'b1;
                        end else if (!cmd_fifo_full) begin
                            if (!w_last_word) begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end else if (w_last_pass) begin
                                r_loops <= '0;
                            end else begin
                                if (!r_inf) r_loops <= r_loops - 16'd1;
                                r_addr <= '0;
                            end
                        end
                    end
                end
                S_DONE:  r_loops <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shim_trigger_seq_player.sv
module tb_shim_trigger_seq_player;
    import shim_trigger_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W:0]   seq_len = '0;
    logic [15:0]       loop_count = '0;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_rd_data = '0;
    logic              cmd_fifo_wr_en;
    logic [31:0]       cmd_fifo_wr_data;
    logic              cmd_fifo_full = 1'b0;
    logic              busy;
    logic              done;
    logic [15:0]       loops_remaining;
    logic              bad_config;

    shim_trigger_seq_player #(.ADDR_W(ADDR_W), .RAM_LATENCY(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .seq_len(seq_len), .loop_count(loop_count),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .cmd_fifo_wr_en(cmd_fifo_wr_en), .cmd_fifo_wr_data(cmd_fifo_wr_data),
        .cmd_fifo_full(cmd_fifo_full), .busy(busy), .done(done),
        .loops_remaining(loops_remaining), .bad_config(bad_config)
    );

    always #5 clk = ~clk;

    // Sequence RAM model, one-cycle read latency
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

    // Write / done logger, sampled on the falling edge
    int          cyc = 0;
    int          rd_cnt = 0;
    int          consec = 0;
    logic        prev_wr = 1'b0;
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q [$];
    logic [15:0] wr_loops_q [$];
    int          done_cyc_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmd_fifo_wr_en) begin
            wr_data_q.push_back(cmd_fifo_wr_data);
            wr_cyc_q.push_back(cyc);
            wr_loops_q.push_back(loops_remaining);
        end
        if (done) done_cyc_q.push_back(cyc);
        if (ram_rd_en) rd_cnt = rd_cnt + 1;
        if (cmd_fifo_wr_en && prev_wr) consec = consec + 1;
        prev_wr = cmd_fifo_wr_en;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] len, input logic [15:0] lc);
        seq_len    = len;
        loop_count = lc;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int i;
        n0 = done_cyc_q.size();
        i  = 0;
        while (done_cyc_q.size() == n0 && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 32'(done_cyc_q.size() > n0), 32'd1);
    endtask

    initial begin
        logic [31:0] list [3];
        logic [15:0] exp_loops [6];
        int base;
        int dbase;
        int nb;
        int n;
        int r0;

        list[0] = 32'h2000_0010;
        list[1] = 32'h8000_0064;
        list[2] = 32'hA000_0000;
        exp_loops[0] = 16'd2; exp_loops[1] = 16'd2; exp_loops[2] = 16'd2;
        exp_loops[3] = 16'd1; exp_loops[4] = 16'd1; exp_loops[5] = 16'd1;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        for (int i = 0; i < 3; i++) mem[i] = list[i];

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_en", 32'(cmd_fifo_wr_en), 0);
        chk("rst_wr_data", cmd_fifo_wr_data, 0);
        chk("rst_rd_en", 32'(ram_rd_en), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_loops", 32'(loops_remaining), 0);
        chk("rst_bad", 32'(bad_config), 0);
        resetn = 1'b1;
        tick();

        // 1: three words, two passes, FIFO never full
        base  = wr_data_q.size();
        dbase = done_cyc_q.size();
        pulse_start(11'd3, 16'd2);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rd_en", 32'(ram_rd_en), 1);
        chk("t1_loops_start", 32'(loops_remaining), 2);
        wait_done("t1_done_seen", 100);
        chk("t1_nwrites", 32'(wr_data_q.size() - base), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_word%0d", k), wr_data_q[base+k], list[k%3]);
            chk($sformatf("t1_loops%0d", k), 32'(wr_loops_q[base+k]), 32'(exp_loops[k]));
        end
        for (int k = 1; k < 6; k++)
            chk($sformatf("t1_gap%0d", k), 32'(wr_cyc_q[base+k] - wr_cyc_q[base+k-1]), 3);
        chk("t1_done_lat", 32'(done_cyc_q[dbase] - wr_cyc_q[base+5]), 1);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_loops_after", 32'(loops_remaining), 0);
        tick(); tick();
        chk("t1_done_count", 32'(done_cyc_q.size() - dbase), 1);

        // 2: FIFO full for 10 cycles over the second push
        base = wr_data_q.size();
        pulse_start(11'd3, 16'd1);
        n = 0;
        while (!(ram_rd_en && ram_addr == 10'd1) && n < 20) begin
            tick();
            n++;
        end
        chk("t2_rd1_seen", 32'(ram_rd_en && ram_addr == 10'd1), 1);
        tick();
        tick();
        cmd_fifo_full = 1'b1;
        nb = wr_data_q.size();
        repeat (10) tick();
        chk("t2_no_wr_full", 32'(wr_data_q.size() - nb), 0);
        cmd_fifo_full = 1'b0;
        wait_done("t2_done_seen", 100);
        chk("t2_nwrites", 32'(wr_data_q.size() - base), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2_word%0d", k), wr_data_q[base+k], list[k]);
        chk("t2_gap1", 32'(wr_cyc_q[base+1] - wr_cyc_q[base]), 13);
        chk("t2_gap2", 32'(wr_cyc_q[base+2] - wr_cyc_q[base+1]), 3);

        // 3: infinite loop of one word, stop on a push cycle
        base = wr_data_q.size();
        pulse_start(11'd1, 16'd0);
        chk("t3_loops_inf", 32'(loops_remaining), 0);
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            tick();
            if (cmd_fifo_wr_en) n++;
        end
        chk("t3_five_seen", 32'(n), 5);
        tick(); tick(); tick();
        chk("t3_push_pending", 32'(cmd_fifo_wr_en), 1);
        stop = 1'b1;
        #1;
        chk("t3_stop_blocks", 32'(cmd_fifo_wr_en), 0);
        tick();
        stop = 1'b0;
        chk("t3_cancel_wr", 32'(cmd_fifo_wr_en), 1);
        chk("t3_cancel_data", cmd_fifo_wr_data, CANCEL_WORD);
        tick();
        chk("t3_done", 32'(done), 1);
        tick();
        chk("t3_busy_after", 32'(busy), 0);
        chk("t3_nwrites", 32'(wr_data_q.size() - base), 6);
        chk("t3_word4", wr_data_q[base+4], list[0]);
        chk("t3_last", wr_data_q[base+5], 32'hE000_0000);
        chk("t3_cancel_gap", 32'(wr_cyc_q[base+5] - wr_cyc_q[base+4]), 4);

        // 4: bad configurations, start ignored while busy, max length
        r0 = rd_cnt;
        pulse_start(11'd0, 16'd1);
        chk("t4_bad_len0", 32'(bad_config), 1);
        chk("t4_busy_len0", 32'(busy), 0);
        repeat (3) tick();
        chk("t4_no_reads", 32'(rd_cnt - r0), 0);
        base = wr_data_q.size();
        pulse_start(11'd2, 16'd1);
        chk("t4_bad_cleared", 32'(bad_config), 0);
        tick();
        pulse_start(11'd0, 16'd1);
        chk("t4_busy_start_ign", 32'(bad_config), 0);
        wait_done("t4_done_seen", 50);
        chk("t4_nwrites", 32'(wr_data_q.size() - base), 2);
        tick();
        pulse_start(11'd1025, 16'd1);
        chk("t4_bad_len1025", 32'(bad_config), 1);
        chk("t4_busy_len1025", 32'(busy), 0);
        pulse_start(11'd1024, 16'd0);
        chk("t4_len1024_ok", 32'(bad_config), 0);
        chk("t4_len1024_busy", 32'(busy), 1);
        repeat (7) tick();
        base = wr_data_q.size();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t4_stop_done", 20);
        chk("t4_stop_cancel", wr_data_q[wr_data_q.size()-1], CANCEL_WORD);
        chk("t4_stop_nwr", 32'(wr_data_q.size() - base), 1);

        // 5: reset in S_WAIT, then start+stop together
        pulse_start(11'd3, 16'd1);
        tick();
        nb = wr_data_q.size();
        resetn = 1'b0;
        tick();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_wr_data", cmd_fifo_wr_data, 0);
        chk("t5_loops", 32'(loops_remaining), 0);
        chk("t5_rd_en", 32'(ram_rd_en), 0);
        resetn = 1'b1;
        repeat (4) tick();
        chk("t5_no_cancel", 32'(wr_data_q.size() - nb), 0);
        base = wr_data_q.size();
        stop = 1'b1;
        pulse_start(11'd3, 16'd1);
        stop = 1'b0;
        chk("t5_start_wins", 32'(busy), 1);
        chk("t5_addr0", 32'(ram_addr), 0);
        wait_done("t5_done_seen", 50);
        chk("t5_nwrites", 32'(wr_data_q.size() - base), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t5_word%0d", k), wr_data_q[base+k], list[k]);

`ifdef SHIM_SEQ_OPCODE_CHECK_EN
        // 6: unknown opcode is replaced by a cancel
        mem[0] = 32'hC000_0000;
        base = wr_data_q.size();
        pulse_start(11'd1, 16'd1);
        wait_done("t6_done_seen", 30);
        chk("t6_bad", 32'(bad_config), 1);
        chk("t6_nwrites", 32'(wr_data_q.size() - base), 1);
        chk("t6_cancel", wr_data_q[base], CANCEL_WORD);
`endif

        chk("no_back_to_back_wr", 32'(consec), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
